// File: rtl/booth_pkg.sv
// Shared constants and state type for the Booth product accumulator.
package booth_pkg;

  localparam int unsigned PROD_W = 8;
  localparam int unsigned ACC_W  = 12;

  // Saturation bounds of the default-width accumulator.
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic {
    ACCUM,
    HOLD
  } acc_state_t;

endpackage

// File: rtl/booth_sat_add.sv
// Combinational signed add of an accumulator and a narrower signed product.
// Reports signed overflow; with BOOTH_ACC_SATURATE_EN defined the sum clamps
// to the accumulator range, otherwise it wraps in two's complement.
module booth_sat_add import booth_pkg::*; #(
  parameter int unsigned PROD_W = booth_pkg::PROD_W,
  parameter int unsigned ACC_W  = booth_pkg::ACC_W
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] product,
  output logic [ACC_W-1:0]  sum,
  output logic              overflow
);

  localparam int unsigned EXT_W = ACC_W + 1 - PROD_W;

  localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [ACC_W:0] wide;

  // One guard bit: the true sum always fits in ACC_W+1 bits.
  assign wide = {acc[ACC_W-1], acc} + {{EXT_W{product[PROD_W-1]}}, product};

  // Top two bits disagree exactly when the true sum leaves the ACC_W range.
  assign overflow = wide[ACC_W] ^ wide[ACC_W-1];

  // Select wrapped or clamped result.
  always_comb begin
    sum = wide[ACC_W-1:0];
`ifdef BOOTH_ACC_SATURATE_EN
    if (overflow) begin
      // Guard bit carries the sign of the true sum.
      sum = wide[ACC_W] ? SAT_MIN : SAT_MAX;
    end
`endif
  end

endmodule

// File: rtl/booth_product_accumulator.sv
// Framed accumulator for signed Booth multiplier products (MAC back end).
// Sums products until in_last or MAX_TERMS terms, then holds the frame result
// (sum, count, sticky overflow) until the consumer takes it.
// Optional: define BOOTH_ACC_SATURATE_EN for a clamping instead of wrapping sum.
module booth_product_accumulator import booth_pkg::*; #(
  parameter int unsigned PROD_W    = booth_pkg::PROD_W,
  parameter int unsigned ACC_W     = booth_pkg::ACC_W,
  parameter int unsigned MAX_TERMS = 32,
  localparam int unsigned CNT_W    = $clog2(MAX_TERMS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_product,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_overflow
);

  acc_state_t       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             res_ovf_q, res_ovf_d;

  logic [ACC_W-1:0] add_sum;
  logic             add_ovf;
  logic             accept;
  logic             close;

  booth_sat_add #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W)
  ) u_add (
    .acc      (acc_q),
    .product  (in_product),
    .sum      (add_sum),
    .overflow (add_ovf)
  );

  assign in_ready  = rst_n && (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign accept    = in_valid && in_ready;
  assign close     = accept && (in_last || (cnt_q == CNT_W'(MAX_TERMS - 1)));

  assign out_sum      = sum_q;
  assign out_count    = count_q;
  assign out_overflow = res_ovf_q;

  // Next-state logic: accumulate in ACCUM, latch result on close, clear on consume.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    sum_d     = sum_q;
    count_d   = count_q;
    res_ovf_d = res_ovf_q;
    unique case (state_q)
      ACCUM: begin
        if (accept) begin
          acc_d = add_sum;
          cnt_d = cnt_q + CNT_W'(1);
          ovf_d = ovf_q | add_ovf;
          if (close) begin
            sum_d     = add_sum;
            count_d   = cnt_q + CNT_W'(1);
            res_ovf_d = ovf_q | add_ovf;
            state_d   = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // State and result registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ACCUM;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      sum_q     <= '0;
      count_q   <= '0;
      res_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      sum_q     <= sum_d;
      count_q   <= count_d;
      res_ovf_q <= res_ovf_d;
    end
  end

endmodule

// File: tb/tb_booth_product_accumulator.sv
// Self-checking bench: integer-level frame model checked every cycle, plus
// literal expectations for each directed frame.
module tb_booth_product_accumulator;

  localparam int PROD_W    = 8;
  localparam int ACC_W     = 12;
  localparam int MAX_TERMS = 32;
  localparam int CNT_W     = $clog2(MAX_TERMS + 1);
  localparam int SMAX      = 2047;
  localparam int SMIN      = -2048;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_product;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic [CNT_W-1:0]  out_count;
  logic              out_overflow;

  int checks = 0;
  int errors = 0;

  // Behavioural model state (plain integers).
  bit m_hold = 0;
  int m_acc = 0, m_cnt = 0;
  bit m_ovf = 0;
  int m_sum = 0, m_count = 0;
  bit m_res_ovf = 0;

  booth_product_accumulator #(
    .PROD_W    (PROD_W),
    .ACC_W     (ACC_W),
    .MAX_TERMS (MAX_TERMS)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_product   (in_product),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sum      (out_sum),
    .out_count    (out_count),
    .out_overflow (out_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame model: true-sum arithmetic, then wrap or clamp into the ACC_W range.
  always @(posedge clk) begin
    int t;
    if (!rst_n) begin
      m_hold = 0; m_acc = 0; m_cnt = 0; m_ovf = 0;
      m_sum = 0; m_count = 0; m_res_ovf = 0;
    end else if (!m_hold) begin
      if (in_valid) begin
        t = m_acc + int'($signed(in_product));
        if (t > SMAX || t < SMIN) begin
          m_ovf = 1;
`ifdef BOOTH_ACC_SATURATE_EN
          t = (t > SMAX) ? SMAX : SMIN;
`else
          t = (t > SMAX) ? t - 4096 : t + 4096;
`endif
        end
        m_acc = t;
        m_cnt++;
        if (in_last || m_cnt == MAX_TERMS) begin
          m_hold = 1; m_sum = m_acc; m_count = m_cnt; m_res_ovf = m_ovf;
        end
      end
    end else if (out_ready) begin
      m_hold = 0; m_acc = 0; m_cnt = 0; m_ovf = 0;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    chk("in_ready", int'(in_ready), int'(rst_n && !m_hold));
    chk("out_valid", int'(out_valid), int'(m_hold));
    chk("out_sum", int'($signed(out_sum)), m_sum);
    chk("out_count", int'(out_count), m_count);
    chk("out_overflow", int'(out_overflow), int'(m_res_ovf));
  end

  // Present one product and hold it until the DUT accepts it.
  task automatic send(input int p, input bit last);
    bit took;
    int n;
    in_valid   = 1'b1;
    in_product = p[PROD_W-1:0];
    in_last    = last;
    took = 0;
    n = 0;
    while (!took && n < 100) begin
      took = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("send_accepted", int'(took), 1);
  endtask

  // Wait (bounded) for a frame result and pin it to hand-computed literals.
  task automatic wait_result(input string name, input int s, input int c, input int o);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_valid"}, int'(out_valid), 1);
    chk({name, "_sum"}, int'($signed(out_sum)), s);
    chk({name, "_count"}, int'(out_count), c);
    chk({name, "_ovf"}, int'(out_overflow), o);
    chk({name, "_model_sum"}, m_sum, s);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_product = '0; in_last = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Four-term frame summing to -4.
    send(3, 0); send(-42, 0); send(10, 0); send(25, 1);
    wait_result("frame4", -4, 4, 0);

    // Forced close after MAX_TERMS terms of +64.
    for (int i = 0; i < MAX_TERMS; i++) send(64, 0);
`ifdef BOOTH_ACC_SATURATE_EN
    wait_result("max_terms", 2047, 32, 1);
`else
    wait_result("max_terms", -2048, 32, 1);
`endif

    // Backpressure: result held while in_valid waits.
    out_ready = 1'b0;
    send(1, 0); send(2, 1);
    wait_result("bp", 3, 2, 0);
    in_valid = 1'b1; in_product = 8'd99; in_last = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_sum_stable", int'($signed(out_sum)), 3);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(99, 1);
    wait_result("bp_next", 99, 1, 0);

    // Single-term frame.
    send(-64, 1);
    wait_result("single", -64, 1, 0);

    // Reset mid-frame discards the partial sum.
    send(10, 0); send(20, 0); send(30, 0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(5, 1);
    wait_result("after_reset", 5, 1, 0);

    // Gapped valid.
    send(7, 0);
    @(posedge clk); #1;
    send(-7, 0);
    @(posedge clk); #1;
    send(1, 1);
    wait_result("gapped", 1, 3, 0);

    // Overflow stays sticky after a later in-range term.
    for (int i = 0; i < 17; i++) send(127, 0);
    send(1, 1);
`ifdef BOOTH_ACC_SATURATE_EN
    wait_result("sticky", 2047, 18, 1);
`else
    wait_result("sticky", -1936, 18, 1);
`endif

    repeat (3) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
